// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and parity-mode codes.
// Pure declarations, no logic or latency; no handshake of its own.
// Parity codes are only decoded when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divisor: counts 0..CLK_DIV-1, bitTick in the last cycle of each bit.
// Latency: restart at edge N gives count 0 in cycle N+1 and bitTick in cycle N+CLK_DIV.
// Backpressure: none; free-running unless restarted.
module uart_baud_gen #(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bitTick,
    output logic preTick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'(CLK_DIV - 2);

    logic [CW-1:0] divCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt <= '0;
        end else if (restart || divCnt == LAST_CNT) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + CW'(1);
        end
    end

    // preTick lets the parent register a pulse that lands on the bitTick cycle
    assign bitTick = (divCnt == LAST_CNT);
    assign preTick = (divCnt == PRE_CNT);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_BITS LSB-first, optional parity, 1/2 stop); parity under `UART_TX_PARITY_EN.
// Latency: accept at edge N -> start bit on TxD in cycles N+1..N+CLK_DIV; tx_done in the frame's last cycle.
// Backpressure: tx_ready only while idle; tx_valid while busy is ignored and must be held until accepted.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CLK_DIV   = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 tx_ready,
    output logic                 TxD,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_tx_state_t       state;
    logic [DATA_BITS-1:0] shiftReg;
    logic [BW-1:0]        bitCnt;
    logic                 stopCnt;
    logic                 twoStopLat;
    logic                 bitTick;
    logic                 preTick;
    logic                 accept;
    logic                 lastStop;

`ifdef UART_TX_PARITY_EN
    logic parEnLat;
    logic parBit;
`else
    logic unusedParity;
    assign unusedParity = ^parity_mode;
`endif

    assign accept   = tx_valid && tx_ready;
    assign lastStop = !twoStopLat || stopCnt;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .bitTick (bitTick),
        .preTick (preTick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            TxD        <= 1'b1;
            busy       <= 1'b0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
            shiftReg   <= '0;
            bitCnt     <= '0;
            stopCnt    <= 1'b0;
            twoStopLat <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parEnLat   <= 1'b0;
            parBit     <= 1'b0;
`endif
        end else begin
            tx_done <= (state == STOP) && lastStop && preTick;
            case (state)
                IDLE: if (accept) begin
                    state      <= START;
                    TxD        <= 1'b0;
                    busy       <= 1'b1;
                    tx_ready   <= 1'b0;
                    shiftReg   <= tx_data;
                    twoStopLat <= two_stop;
                    bitCnt     <= '0;
                    stopCnt    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                    // parity is fixed at accept, so later input changes cannot leak in
                    parEnLat   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                    parBit     <= (^tx_data) ^ (parity_mode == PAR_ODD);
`endif
                end
                START: if (bitTick) begin
                    state <= DATA;
                    TxD   <= shiftReg[0];
                end
                DATA: if (bitTick) begin
                    if (bitCnt == LAST_BIT) begin
                        state <= STOP;
                        TxD   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (parEnLat) begin
                            state <= PARITY;
                            TxD   <= parBit;
                        end
`endif
                    end else begin
                        bitCnt   <= bitCnt + BW'(1);
                        shiftReg <= shiftReg >> 1;
                        TxD      <= shiftReg[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (bitTick) begin
                    state <= STOP;
                    TxD   <= 1'b1;
                end
`endif
                STOP: if (bitTick) begin
                    if (lastStop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else begin
                        stopCnt <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    TxD      <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param (DATA_BITS=8, CLK_DIV=4): per-cycle line/handshake checks.
// Parity vectors are used when UART_TX_PARITY_EN is defined, otherwise parity_mode must be ignored.
module tb_uart_tx_param;

    localparam int DB  = 8;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic [1:0]    parity_mode = 2'b00;
    logic          two_stop = 1'b0;
    logic          tx_ready;
    logic          TxD;
    logic          busy;
    logic          tx_done;

    int vectors = 0;
    int errors  = 0;

    uart_tx_param #(.DATA_BITS(DB), .CLK_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .tx_ready    (tx_ready),
        .TxD         (TxD),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; the following posedge is the accept edge.
    task automatic runFrame(input logic [DB-1:0] d, input logic [1:0] pm, input logic ts,
                            input int pbit, input bit mutate, input bit keepValid,
                            input logic [DB-1:0] nextD, input string tag);
        logic bits [0:12];
        int   nb;
        int   len;
        tx_valid    = 1'b1;
        tx_data     = d;
        parity_mode = pm;
        two_stop    = ts;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1+i] = d[i];
        nb = 1 + DB;
        if (pbit >= 0) begin
            bits[nb] = pbit[0];
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        if (ts) begin
            bits[nb] = 1'b1;
            nb++;
        end
        len = nb * DIV;
        @(posedge clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (keepValid) tx_data = nextD;
                else tx_valid = 1'b0;
            end
            check($sformatf("%s TxD c%0d", tag, k), TxD, bits[(k-1)/DIV]);
            check($sformatf("%s busy c%0d", tag, k), busy, 1'b1);
            check($sformatf("%s ready c%0d", tag, k), tx_ready, 1'b0);
            check($sformatf("%s done c%0d", tag, k), tx_done, (k == len));
            if (mutate) begin
                tx_data     = DB'($urandom);
                parity_mode = 2'($urandom);
                two_stop    = 1'($urandom);
                tx_valid    = (k < len);
            end
        end
        @(negedge clk);
        check({tag, " idle TxD"}, TxD, 1'b1);
        check({tag, " idle ready"}, tx_ready, 1'b1);
        check({tag, " idle busy"}, busy, 1'b0);
        check({tag, " idle done"}, tx_done, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst TxD", TxD, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst ready", tx_ready, 1'b1);
        check("rst done", tx_done, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("post-rst ready", tx_ready, 1'b1);

        runFrame(8'hD9, 2'b00, 1'b0, -1, 1'b0, 1'b0, 8'h00, "d9_8n1");
`ifdef UART_TX_PARITY_EN
        runFrame(8'hD9, 2'b01, 1'b1, 1, 1'b0, 1'b0, 8'h00, "d9_even_2s");
        runFrame(8'hD9, 2'b10, 1'b0, 0, 1'b0, 1'b0, 8'h00, "d9_odd_1s");
        runFrame(8'hD9, 2'b11, 1'b0, -1, 1'b0, 1'b0, 8'h00, "d9_mode11");
`else
        runFrame(8'hD9, 2'b01, 1'b0, -1, 1'b0, 1'b0, 8'h00, "d9_pm01_ignored");
        runFrame(8'hD9, 2'b10, 1'b1, -1, 1'b0, 1'b0, 8'h00, "d9_pm10_2s");
`endif

        runFrame(8'h55, 2'b00, 1'b0, -1, 1'b0, 1'b1, 8'hAA, "b2b_55");
        runFrame(8'hAA, 2'b00, 1'b0, -1, 1'b0, 1'b0, 8'h00, "b2b_aa");

`ifdef UART_TX_PARITY_EN
        runFrame(8'h3C, 2'b10, 1'b1, 1, 1'b1, 1'b0, 8'h00, "mutate_odd");
`else
        runFrame(8'h3C, 2'b00, 1'b1, -1, 1'b1, 1'b0, 8'h00, "mutate");
`endif

        // abandon a frame during DATA
        tx_valid    = 1'b1;
        tx_data     = 8'hF0;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-abort busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("abort TxD", TxD, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort ready", tx_ready, 1'b1);
        check("abort done", tx_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort hold done %0d", i), tx_done, 1'b0);
        end
        reset = 1'b1;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            check($sformatf("post-abort done %0d", i), tx_done, 1'b0);
            check($sformatf("post-abort TxD %0d", i), TxD, 1'b1);
        end
        runFrame(8'hA5, 2'b00, 1'b0, -1, 1'b0, 1'b0, 8'h00, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, successor to the fixed 8N1 `TX` block: configurable data width and baud divisor, runtime-selectable parity and stop-bit count, valid/ready input handshake and an end-of-frame pulse. It sits between a byte producer (CPU register, FIFO) and the serial `TxD` pin, and is the transmit half of the UART top level.

## Interface
- `DATA_BITS`, default 8: payload bits per frame; legal range 5..9.
- `CLK_DIV`, default 868: `clk` cycles per serial bit, ≥ 2 (868 gives 115200 baud at 100 MHz).
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: producer has a frame to send.
- `tx_data` in `DATA_BITS`: payload; sent LSB first.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `two_stop` in 1: 1 selects two stop bits, 0 selects one.
- `tx_ready` out 1: block can accept a frame this cycle.
- `TxD` out 1: serial line; idle high.
- `busy` out 1: frame in progress.
- `tx_done` out 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- Reset values: `TxD`=1, `busy`=0, `tx_ready`=1, `tx_done`=0, state IDLE, all counters 0.
- Accept: `tx_valid && tx_ready` at a rising edge. On accept, latch `tx_data`, `parity_mode` and `two_stop`. Later changes to these inputs do not affect the frame in progress.
- States:
  - IDLE → START on accept.
  - START → DATA.
  - DATA (`DATA_BITS` bits) → PARITY if parity enabled, else STOP.
  - PARITY → STOP.
  - STOP (1 or 2 bits) → IDLE.
- Each state holds for exactly `CLK_DIV` cycles per bit. The bit counter is `$clog2(DATA_BITS)` wide. The divisor counter is `$clog2(CLK_DIV)` wide, counts 0..CLK_DIV-1 and wraps to 0 on every bit boundary.
- Line levels: START drives 0; DATA drives the shift register LSB; STOP drives 1. PARITY drives the XOR of the latched data for even parity, and its inverse for odd parity.
- `tx_ready` = (state == IDLE). `busy` = !`tx_ready`.
- Reset asserted mid-frame: `TxD` returns to 1 asynchronously and the frame is abandoned. No `tx_done` pulse is emitted.

## Timing
- Accept at edge N: `TxD` falls and `busy` rises after edge N (registered), so the start bit occupies cycles N+1..N+CLK_DIV.
- Frame length in cycles = (1 + DATA_BITS + P + S) × CLK_DIV, where P ∈ {0,1} and S ∈ {1,2}.
- `tx_done` is high in the final cycle of the last stop bit. The state is IDLE and `tx_ready`=1 from the next cycle.
- Back-to-back frames: if `tx_valid` is held high, the next accept happens in the first IDLE cycle. This gives exactly one idle cycle between the stop bit and the next start bit.
- `tx_valid` while busy is ignored and has no side effects; the producer must hold it until accepted.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state, parity logic and `parity_mode` decoding are compiled in.
- `UART_TX_PARITY_EN` not defined: the `parity_mode` port remains but is ignored. P is always 0, and DATA goes straight to STOP.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
  
  The same package is reused by the future receiver.
- One sub-module, `uart_baud_gen`: divisor counter with a restart input and a one-cycle `bit_tick` output. It is cleared on accept so bit boundaries align to the accept edge.

## Test plan
- DATA_BITS=8, CLK_DIV=4, no parity, one stop bit, `tx_data`=8'hD9 → `TxD` bits 0,1,0,0,1,1,0,1,1,1, each 4 cycles; `busy` high for 40 cycles; `tx_done` in cycle 40.
- Same data with even parity and two stop bits → parity bit 1; frame 48 cycles. With odd parity → parity bit 0.
- `tx_valid` held high with 8'h55 followed by 8'hAA → second start bit exactly one cycle after the first `tx_done`; no data corruption.
- Toggle `tx_data`, `parity_mode` and `two_stop` mid-frame → transmitted frame unchanged.
- Drop `reset` during the DATA state → `TxD`=1 and `busy`=0 immediately; no `tx_done`; a new frame after reset is correct.
- Build without `UART_TX_PARITY_EN` and set `parity_mode`=01 → 40-cycle frame with no parity bit.
